// File: rtl/rl_state_encoder.sv
// ============================================================================
// Module   : rl_state_encoder
// Summary  : Snapshots game state on request and serially encodes it into the
//            33-entry Q-format observation vector. It then runs the inference
//            start/done handshake and the action valid/ack handshake.
//            Optional WAIT watchdog: define RL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rl_state_encoder #(
  parameter int         IN_DIM         = 33,
  parameter int         FRAC_BITS      = 10,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [3:0] DEFAULT_ACTION = 4'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  output logic                    req_ready,
  input  logic [3:0]              live_left,
  input  logic [3:0]              blank_left,
  input  logic [3:0]              cur_index,
  input  logic [3:0]              flags,
  input  logic [3:0]              player_hp,
  input  logic [3:0]              opp_hp,
  input  logic [27:0]             player_items,
  input  logic [27:0]             opp_items,
  input  logic [1:0]              cuffed,
  input  logic [15:0]             knowledge,
  output logic [IN_DIM-1:0][15:0] in_vec,
  output logic                    start,
  input  logic                    infer_done,
  input  logic [3:0]              action_in,
  output logic [3:0]              action,
  output logic                    action_valid,
  input  logic                    action_ack,
  output logic                    timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_ENCODE  = 3'd2,
    S_START   = 3'd3,
    S_WAIT    = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  localparam logic [15:0] c_one      = 16'(1) << FRAC_BITS;
  localparam logic [15:0] c_neg_one  = 16'd0 - c_one;
  localparam logic [5:0]  c_last_idx = 6'(IN_DIM - 1);

  function automatic logic [15:0] q_of(input logic [3:0] v);
    return {12'd0, v} << FRAC_BITS;
  endfunction

  state_t          r_state;
  logic [5:0]      r_idx;

  logic [3:0]      r_live;
  logic [3:0]      r_blank;
  logic [3:0]      r_cur;
  logic [3:0]      r_flags;
  logic [3:0]      r_php;
  logic [3:0]      r_ohp;
  logic [6:0][3:0] r_pitems;
  logic [6:0][3:0] r_oitems;
  logic [1:0]      r_cuffed;
  logic [7:0][1:0] r_know;

  logic [3:0]      w_val;
  logic [2:0]      w_sub;
  logic [15:0]     w_elem;

`ifdef RL_TIMEOUT_EN
  localparam logic [15:0] c_wait_limit = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wait_cnt;
`else
  // Watchdog parameters have no effect in this build.
  if (TIMEOUT_CYCLES == 0 && DEFAULT_ACTION == 4'd15) begin : g_timeout_cfg_unused
  end
  assign timeout = 1'b0;
`endif

  // Element selected by r_idx, taken from the snapshot only.
  always_comb begin
    w_val  = 4'd0;
    w_sub  = 3'd0;
    w_elem = 16'd0;
    case (r_idx) inside
      6'd0:          w_val = r_live;
      6'd1:          w_val = r_blank;
      6'd2:          w_val = r_cur;
      6'd3:          w_val = {3'd0, r_flags[0]};
      6'd4:          w_val = {3'd0, r_flags[1]};
      6'd5:          w_val = {3'd0, r_flags[2]};
      6'd6:          w_val = {3'd0, r_flags[3]};
      6'd7:          w_val = r_php;
      6'd8:          w_val = r_ohp;
      [6'd9:6'd15]: begin
        w_sub = 3'(r_idx - 6'd9);
        w_val = r_pitems[w_sub];
      end
      6'd16:         w_val = {3'd0, r_cuffed[0]};
      6'd17:         w_val = {3'd0, r_cuffed[1]};
      [6'd18:6'd24]: begin
        w_sub = 3'(r_idx - 6'd18);
        w_val = r_oitems[w_sub];
      end
      default:       w_val = 4'd0;
    endcase

    if (r_idx >= 6'd25) begin
      w_sub = 3'(r_idx - 6'd25);
      case (r_know[w_sub])
        2'b01:   w_elem = c_one;
        2'b10:   w_elem = c_neg_one;
        default: w_elem = 16'd0;
      endcase
    end else begin
      w_elem = q_of(w_val);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= 6'd0;
      r_live       <= '0;
      r_blank      <= '0;
      r_cur        <= '0;
      r_flags      <= '0;
      r_php        <= '0;
      r_ohp        <= '0;
      r_pitems     <= '0;
      r_oitems     <= '0;
      r_cuffed     <= '0;
      r_know       <= '0;
      in_vec       <= '0;
      start        <= 1'b0;
      action       <= 4'd0;
      action_valid <= 1'b0;
      req_ready    <= 1'b1;
`ifdef RL_TIMEOUT_EN
      timeout      <= 1'b0;
      r_wait_cnt   <= 16'd0;
`endif
    end else begin
      start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_live    <= live_left;
            r_blank   <= blank_left;
            r_cur     <= cur_index;
            r_flags   <= flags;
            r_php     <= player_hp;
            r_ohp     <= opp_hp;
            r_pitems  <= player_items;
            r_oitems  <= opp_items;
            r_cuffed  <= cuffed;
            r_know    <= knowledge;
            req_ready <= 1'b0;
            r_state   <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_idx   <= 6'd0;
          r_state <= S_ENCODE;
        end
        S_ENCODE: begin
          in_vec[r_idx] <= w_elem;
          if (r_idx == c_last_idx) begin
            start   <= 1'b1;
            r_state <= S_START;
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end
        S_START: begin
`ifdef RL_TIMEOUT_EN
          r_wait_cnt <= 16'd0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving in the expiry cycle takes priority over the watchdog.
          if (infer_done) begin
            action       <= action_in;
            action_valid <= 1'b1;
`ifdef RL_TIMEOUT_EN
            timeout      <= 1'b0;
`endif
            r_state      <= S_HOLD;
          end
`ifdef RL_TIMEOUT_EN
          else if (r_wait_cnt == c_wait_limit) begin
            action       <= DEFAULT_ACTION;
            action_valid <= 1'b1;
            timeout      <= 1'b1;
            r_state      <= S_HOLD;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
`endif
        end
        S_HOLD: begin
          if (action_ack) begin
            action_valid <= 1'b0;
`ifdef RL_TIMEOUT_EN
            timeout      <= 1'b0;
`endif
            req_ready    <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rl_state_encoder.sv
// ============================================================================
// Module   : tb_rl_state_encoder
// Summary  : Directed self-checking bench for rl_state_encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rl_state_encoder;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req = 1'b0;
  logic             req_ready;
  logic [3:0]       live_left = '0, blank_left = '0, cur_index = '0, flags = '0;
  logic [3:0]       player_hp = '0, opp_hp = '0;
  logic [27:0]      player_items = '0, opp_items = '0;
  logic [1:0]       cuffed = '0;
  logic [15:0]      knowledge = '0;
  logic [32:0][15:0] in_vec;
  logic             start;
  logic             infer_done = 1'b0;
  logic [3:0]       action_in = '0;
  logic [3:0]       action;
  logic             action_valid;
  logic             action_ack = 1'b0;
  logic             timeout;

  int n_checks    = 0;
  int n_pass      = 0;
  int cyc         = 0;
  int start_count = 0;
  int start_cyc   = -1;

  logic [15:0] exp_vec [0:32] = '{
    16'd3072, 16'd2048, 16'd5120, 16'd0,    16'd1024, 16'd0,    16'd1024, 16'd4096, 16'd3072,
    16'd2048, 16'd0,    16'd3072, 16'd1024, 16'd0,    16'd2048, 16'd1024,
    16'd0,    16'd1024,
    16'd5120, 16'd1024, 16'd0,    16'd0,    16'd3072, 16'd0,    16'd0,
    16'hFC00, 16'h0400, 16'd0,    16'd0,    16'd0,    16'd0,    16'h0400, 16'hFC00
  };

  rl_state_encoder #(
    .IN_DIM         (33),
    .FRAC_BITS      (10),
    .TIMEOUT_CYCLES (16),
    .DEFAULT_ACTION (4'd3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_ready    (req_ready),
    .live_left    (live_left),
    .blank_left   (blank_left),
    .cur_index    (cur_index),
    .flags        (flags),
    .player_hp    (player_hp),
    .opp_hp       (opp_hp),
    .player_items (player_items),
    .opp_items    (opp_items),
    .cuffed       (cuffed),
    .knowledge    (knowledge),
    .in_vec       (in_vec),
    .start        (start),
    .infer_done   (infer_done),
    .action_in    (action_in),
    .action       (action),
    .action_valid (action_valid),
    .action_ack   (action_ack),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
  endtask

  // Cycle c is the interval after the c-th rising edge following acceptance.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (start === 1'b1) begin
      start_count++;
      start_cyc = cyc;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_req();
    req = 1'b1;
    cyc = 0;
    tick();
    req = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_start", start, 0);
    check("rst_valid", action_valid, 0);
    check("rst_action", action, 0);
    check("rst_timeout", timeout, 0);
    check("rst_vec_zero", {31'd0, in_vec == '0}, 1);
    rst = 1'b0;
    tick();

    live_left = 4'd3; blank_left = 4'd2; cur_index = 4'd5; flags = 4'b1010;
    player_hp = 4'd4; opp_hp = 4'd3;
    player_items = 28'h1201302; opp_items = 28'h0030015;
    cuffed = 2'b10; knowledge = 16'h9306;
    do_req();
    check("busy_req_ready", req_ready, 0);
    live_left = 4'd15; blank_left = 4'd15; cur_index = 4'd15; flags = 4'hF;
    player_hp = 4'd15; opp_hp = 4'd15;
    player_items = 28'hFFFFFFF; opp_items = 28'hFFFFFFF;
    cuffed = 2'b11; knowledge = 16'h5555;
    run_to(20);
    live_left = 4'd1; knowledge = 16'hAAAA; player_items = 28'h7777777;
    run_to(34);
    check("start_before_35", start, 0);
    tick();
    check("start_cycle_35", start, 1);
    infer_done = 1'b1; action_in = 4'd9;
    tick();
    infer_done = 1'b0;
    check("start_one_cycle", start, 0);
    check("done_in_start_ignored", action_valid, 0);
    for (int i = 0; i < 33; i++) check($sformatf("vec%0d", i), in_vec[i], exp_vec[i]);
    run_to(40);
    check("no_valid_before_done", action_valid, 0);
    infer_done = 1'b1; action_in = 4'd7;
    tick();
    infer_done = 1'b0; action_in = 4'd0;
    check("hold_valid", action_valid, 1);
    check("hold_action", action, 7);
    check("hold_timeout", timeout, 0);
    run_to(42);
    req = 1'b1;
    tick();
    check("hold_req_ignored", req_ready, 0);
    check("hold_valid_kept", action_valid, 1);
    run_to(45);
    action_ack = 1'b1;
    tick();
    action_ack = 1'b0;
    req = 1'b0;
    check("ack_valid_low", action_valid, 0);
    check("ack_req_ready", req_ready, 1);
    check("vec_stable_after", in_vec[0], 16'd3072);
    check("vec_stable_know", in_vec[32], 16'hFC00);
    tick();
    check("req_dropped", req_ready, 1);
    check("single_start", start_count, 1);
    check("start_cyc", start_cyc, 35);

    do_req();
    run_to(12);
    #2 rst = 1'b1;
    #1;
    check("async_start", start, 0);
    check("async_valid", action_valid, 0);
    check("async_action", action, 0);
    check("async_timeout", timeout, 0);
    check("async_req_ready", req_ready, 1);
    check("async_vec_zero", {31'd0, in_vec == '0}, 1);
    tick();
    rst = 1'b0;
    repeat (40) tick();
    check("no_start_after_rst", start_count, 1);
    check("idle_after_rst", req_ready, 1);

`ifdef RL_TIMEOUT_EN
    do_req();
    run_to(51);
    check("wd_not_yet", action_valid, 0);
    tick();
    check("wd_valid", action_valid, 1);
    check("wd_timeout", timeout, 1);
    check("wd_action", action, 3);
    action_ack = 1'b1;
    tick();
    action_ack = 1'b0;
    check("wd_ack_timeout", timeout, 0);
    check("wd_ack_valid", action_valid, 0);
`else
    do_req();
    run_to(300);
    check("nowd_still_wait", action_valid, 0);
    check("nowd_timeout", timeout, 0);
    infer_done = 1'b1; action_in = 4'd12;
    tick();
    infer_done = 1'b0;
    check("nowd_valid", action_valid, 1);
    check("nowd_action", action, 12);
    action_ack = 1'b1;
    tick();
    action_ack = 1'b0;
    check("nowd_ack", req_ready, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
